exe_ctrl_seq: RTL and testbench
===============================

EXE_CTRL_SEQ -- requirements
Module: exe_ctrl_seq

Interface
REQ-001 SHALL have parameter TRIG_TIMEOUT, default 16, giving the max cycles to wait for trig_done.
REQ-002 SHALL have parameter FLAG_W, default 4, giving the flag register width {N,Z,C,V}.
REQ-003 clk  in  1  single clock, all state on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 in_valid  in  1  decode bundle valid.
REQ-006 in_ready  out  1  sequencer accepts a bundle this cycle.
REQ-007 in_regWrite, in_memWrite, in_memPixWrite, in_branch, in_aluSrc, in_flagWrite, in_trigControl, in_pcSrc  in  1 each  decode control bits.
REQ-008 in_memToReg  in  2  writeback select; in_aluControl  in  4  ALU op.
REQ-009 in_cond  in  4  condition code.
REQ-010 alu_flags  in  FLAG_W  combinational ALU flags for the bundle being accepted (or completing, for trig ops).
REQ-011 trig_start  out  1  one-cycle start pulse to the SIN/COS unit.
REQ-012 trig_done  in  1  SIN/COS unit completion pulse.
REQ-013 out_valid  out  1, out_ready  in  1  handshake to the memory stage.
REQ-014 out_regWrite, out_memWrite, out_memPixWrite, out_memToReg[1:0], out_aluControl[3:0]  out  registered forwarded bundle.
REQ-015 flags  out  FLAG_W  architectural flag register.
REQ-016 pc_src_o, flush_o  out  1 each  branch-taken redirect and decode-flush pulses.
REQ-017 trig_err  out  1  sticky SIN/COS timeout error.

Function
REQ-018 States SHALL be IDLE and TRIG_WAIT.
REQ-019 in_ready SHALL equal (state==IDLE) && (!out_valid || out_ready) && !flush_o.
REQ-020 Accept SHALL occur when in_valid && in_ready; no bundle is accepted otherwise.
REQ-021 Condition pass SHALL be decoded from the current flags register (no same-cycle bypass):
- 0000 EQ: Z=1
- 0001 NE: Z=0
- 1010 GE: N==V
- 1011 LT: N!=V
- all other codes: always.
REQ-022 On a condition fail, the bundle SHALL be forwarded with regWrite, memWrite, memPixWrite, flagWrite and branch cleared, and trig_start SHALL be suppressed.
REQ-023 On accept of a non-trig bundle, the next cycle SHALL present out_valid=1 with the bundle registered (1-cycle latency).
REQ-024 out_valid and out_* SHALL hold stable until out_valid && out_ready.
REQ-025 On accept with trigControl=1 and condition pass, trig_start=1 SHALL be driven in the cycle after accept, and the state SHALL go to TRIG_WAIT.
REQ-026 In TRIG_WAIT, when trig_done=1, the sequencer SHALL load the output register, set out_valid=1 the next cycle and return to IDLE.
REQ-027 A wait counter SHALL count cycles in TRIG_WAIT.
REQ-028 If the wait counter reaches TRIG_TIMEOUT without trig_done:
- trig_err SHALL be set (sticky until rst)
- the bundle SHALL be forwarded with regWrite=0
- the state SHALL return to IDLE.
REQ-029 trig_done outside TRIG_WAIT SHALL be ignored.
REQ-030 trig_done in the same cycle as timeout SHALL count as completion with no error.
REQ-031 flags SHALL load alu_flags:
- at accept, for a passing non-trig bundle with flagWrite=1
- at trig_done, for a passing trig bundle with flagWrite=1.
REQ-032 A bundle with both branch and flagWrite SHALL evaluate its condition on the old flags.
REQ-033 A passing bundle with branch=1 SHALL pulse pc_src_o=1 and flush_o=1 for exactly one cycle, aligned with its out_valid rising.
REQ-034 During the flush_o cycle, in_ready SHALL be 0.
REQ-035 A bundle with aluControl MUL (0b1010 class) and trigControl=0 SHALL be treated as single-cycle.

Reset
REQ-036 On rst=1 at a clock edge, the following SHALL clear to 0 and the state SHALL go to IDLE, regardless of any in-flight TRIG_WAIT: out_valid, out_*, flags, trig_start, pc_src_o, flush_o, trig_err, wait counter.
REQ-037 A trig_done arriving after reset SHALL be ignored.
REQ-038 in_ready SHALL be 0 while rst=1 and 1 in the first cycle after rst deasserts.

Verification
REQ-039 Back-to-back: ADD bundles on 3 consecutive cycles with out_ready=1 -> out_valid=1 on cycles 2-4, bundles in order, in_ready never low.
REQ-040 Backpressure: out_ready=0 for 3 cycles with a bundle held -> out_* stable, in_ready=0, no input lost; release -> next bundle accepted the same cycle.
REQ-041 Conditional: flags Z=1, branch with cond=0001 -> forwarded with regWrite=0, no pc_src_o; with cond=0000 -> pc_src_o and flush_o each high exactly 1 cycle.
REQ-042 Trig: SIN bundle, trig_done 5 cycles after trig_start -> in_ready=0 throughout, out_valid the cycle after trig_done, flags updated if flagWrite=1.
REQ-043 Timeout: SIN bundle with no trig_done -> after 16 TRIG_WAIT cycles trig_err=1, out_regWrite=0, state IDLE; trig_err stays 1 until rst.
REQ-044 Reset mid-op: rst in the 3rd TRIG_WAIT cycle -> all outputs 0 the next cycle; a later trig_done produces no output.

Source files
------------

// File: rtl/exe_ctrl_seq.sv
// Execute-stage control sequencer: accepts decoded control bundles, evaluates
// the condition code against the flag register, forwards the bundle to the
// memory stage, and parks multi-cycle SIN/COS operations in a wait state
// guarded by a timeout.
module exe_ctrl_seq #(
  parameter int TRIG_TIMEOUT = 16,
  parameter int FLAG_W       = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_regWrite,
  input  logic              in_memWrite,
  input  logic              in_memPixWrite,
  input  logic              in_branch,
  input  logic              in_aluSrc,
  input  logic              in_flagWrite,
  input  logic              in_trigControl,
  input  logic              in_pcSrc,
  input  logic [1:0]        in_memToReg,
  input  logic [3:0]        in_aluControl,
  input  logic [3:0]        in_cond,
  input  logic [FLAG_W-1:0] alu_flags,
  output logic              trig_start,
  input  logic              trig_done,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_regWrite,
  output logic              out_memWrite,
  output logic              out_memPixWrite,
  output logic [1:0]        out_memToReg,
  output logic [3:0]        out_aluControl,
  output logic [FLAG_W-1:0] flags,
  output logic              pc_src_o,
  output logic              flush_o,
  output logic              trig_err
);

  // Flag bit positions within {N,Z,C,V}; C is carried but not decoded here.
  localparam int N_BIT = FLAG_W - 1;
  localparam int Z_BIT = FLAG_W - 2;
  localparam int V_BIT = FLAG_W - 4;
  localparam int CNT_W = $clog2(TRIG_TIMEOUT + 1);

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;

  typedef enum logic {
    IDLE      = 1'b0,
    TRIG_WAIT = 1'b1
  } state_t;

  // Fields forwarded to the memory stage.
  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       mem_pix_write;
    logic [1:0] mem_to_reg;
    logic [3:0] alu_control;
  } fwd_t;

  state_t           state;
  fwd_t             out_q;
  fwd_t             in_fwd;
  fwd_t             pend_fwd;
  logic             pend_flag_write;
  logic             pend_branch;
  logic [CNT_W-1:0] wait_cnt;
  logic             cond_pass;
  logic             accept;
  logic             trig_go;
  logic             timeout;

  // ALU-source and PC-source selects are consumed elsewhere in the datapath.
  logic unused_ok;
  assign unused_ok = &{1'b0, in_aluSrc, in_pcSrc};

  // Condition decode against the architectural flags (no bypass of alu_flags).
  always_comb begin
    // NOTE: default assignment first so every path drives cond_pass; no latch.
    cond_pass = 1'b1;
    unique case (in_cond)
      COND_EQ: cond_pass = flags[Z_BIT];
      COND_NE: cond_pass = !flags[Z_BIT];
      COND_GE: cond_pass = (flags[N_BIT] == flags[V_BIT]);
      COND_LT: cond_pass = (flags[N_BIT] != flags[V_BIT]);
      default: cond_pass = 1'b1;
    endcase
  end

  // Incoming bundle with side effects squashed when the condition fails.
  always_comb begin
    in_fwd.reg_write     = in_regWrite    && cond_pass;
    in_fwd.mem_write     = in_memWrite    && cond_pass;
    in_fwd.mem_pix_write = in_memPixWrite && cond_pass;
    in_fwd.mem_to_reg    = in_memToReg;
    in_fwd.alu_control   = in_aluControl;
  end

  assign in_ready = !rst && (state == IDLE) && (!out_valid || out_ready) && !flush_o;
  assign accept   = in_valid && in_ready;
  assign trig_go  = accept && in_trigControl && cond_pass;
  assign timeout  = (wait_cnt == CNT_W'(TRIG_TIMEOUT - 1));

  assign out_regWrite    = out_q.reg_write;
  assign out_memWrite    = out_q.mem_write;
  assign out_memPixWrite = out_q.mem_pix_write;
  assign out_memToReg    = out_q.mem_to_reg;
  assign out_aluControl  = out_q.alu_control;

  // Sequencer FSM: output register, flags, pulses, trig wait and timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the parked bundle is reset too, so nothing stale can ever leak out.
      state           <= IDLE;
      out_valid       <= 1'b0;
      out_q           <= '0;
      pend_fwd        <= '0;
      pend_flag_write <= 1'b0;
      pend_branch     <= 1'b0;
      flags           <= '0;
      trig_start      <= 1'b0;
      pc_src_o        <= 1'b0;
      flush_o         <= 1'b0;
      trig_err        <= 1'b0;
      wait_cnt        <= '0;
    end else begin
      // NOTE: non-blocking throughout; later assignments in this block override
      // these pulse defaults without ordering hazards between registers.
      trig_start <= 1'b0;
      pc_src_o   <= 1'b0;
      flush_o    <= 1'b0;
      if (out_valid && out_ready) out_valid <= 1'b0;

      unique case (state)
        IDLE: begin
          if (trig_go) begin
            pend_fwd        <= in_fwd;
            pend_flag_write <= in_flagWrite;
            pend_branch     <= in_branch;
            wait_cnt        <= '0;
            trig_start      <= 1'b1;
            state           <= TRIG_WAIT;
          end else if (accept) begin
            out_q     <= in_fwd;
            out_valid <= 1'b1;
            if (cond_pass && in_flagWrite) flags <= alu_flags;
            if (cond_pass && in_branch) begin
              pc_src_o <= 1'b1;
              flush_o  <= 1'b1;
            end
          end
        end
        TRIG_WAIT: begin
          if (trig_done) begin
            out_q     <= pend_fwd;
            out_valid <= 1'b1;
            if (pend_flag_write) flags <= alu_flags;
            if (pend_branch) begin
              pc_src_o <= 1'b1;
              flush_o  <= 1'b1;
            end
            state <= IDLE;
          end else if (timeout) begin
            out_q           <= pend_fwd;
            out_q.reg_write <= 1'b0;
            out_valid       <= 1'b1;
            trig_err        <= 1'b1;
            state           <= IDLE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_ctrl_seq.sv
// Self-checking bench for exe_ctrl_seq: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_exe_ctrl_seq;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid, in_ready;
  logic       in_regWrite, in_memWrite, in_memPixWrite, in_branch;
  logic       in_aluSrc, in_flagWrite, in_trigControl, in_pcSrc;
  logic [1:0] in_memToReg;
  logic [3:0] in_aluControl, in_cond, alu_flags;
  logic       trig_start, trig_done;
  logic       out_valid, out_ready;
  logic       out_regWrite, out_memWrite, out_memPixWrite;
  logic [1:0] out_memToReg;
  logic [3:0] out_aluControl, flags;
  logic       pc_src_o, flush_o, trig_err;

  int checks = 0;
  int errors = 0;

  exe_ctrl_seq #(.TRIG_TIMEOUT(TO), .FLAG_W(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_regWrite(in_regWrite), .in_memWrite(in_memWrite),
    .in_memPixWrite(in_memPixWrite), .in_branch(in_branch),
    .in_aluSrc(in_aluSrc), .in_flagWrite(in_flagWrite),
    .in_trigControl(in_trigControl), .in_pcSrc(in_pcSrc),
    .in_memToReg(in_memToReg), .in_aluControl(in_aluControl),
    .in_cond(in_cond), .alu_flags(alu_flags), .trig_start(trig_start),
    .trig_done(trig_done), .out_valid(out_valid), .out_ready(out_ready),
    .out_regWrite(out_regWrite), .out_memWrite(out_memWrite),
    .out_memPixWrite(out_memPixWrite), .out_memToReg(out_memToReg),
    .out_aluControl(out_aluControl), .flags(flags), .pc_src_o(pc_src_o),
    .flush_o(flush_o), .trig_err(trig_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rw, mw, mpw, br, src, fw, trig, pcs;
    logic [1:0] m2r;
    logic [3:0] alu, cond;
  } bun_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit         m_wait, m_ov, m_err, m_ts, m_redir, m_accepted;
  int         m_elapsed;
  bun_t       m_pend;
  logic       m_rw, m_mw, m_mpw;
  logic [1:0] m_m2r;
  logic [3:0] m_alu, m_flags;

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    case (c)
      4'h0:    return f[2] == 1'b1;
      4'h1:    return f[2] == 1'b0;
      4'hA:    return f[3] == f[0];
      4'hB:    return f[3] != f[0];
      default: return 1'b1;
    endcase
  endfunction

  function automatic bun_t cur_in();
    bun_t b;
    b.rw = in_regWrite; b.mw = in_memWrite; b.mpw = in_memPixWrite; b.br = in_branch;
    b.src = in_aluSrc; b.fw = in_flagWrite; b.trig = in_trigControl; b.pcs = in_pcSrc;
    b.m2r = in_memToReg; b.alu = in_aluControl; b.cond = in_cond;
    return b;
  endfunction

  task automatic emit(input bun_t b, input bit keep_rw, input bit keep_mem);
    m_ov  = 1'b1;
    m_rw  = b.rw && keep_rw;
    m_mw  = b.mw && keep_mem;
    m_mpw = b.mpw && keep_mem;
    m_m2r = b.m2r;
    m_alu = b.alu;
  endtask

  initial begin
    m_wait = 0; m_ov = 0; m_err = 0; m_ts = 0; m_redir = 0; m_accepted = 0;
    m_elapsed = 0; m_rw = 0; m_mw = 0; m_mpw = 0; m_m2r = 0; m_alu = 0; m_flags = 0;
  end

  always @(posedge clk) begin : model
    bit   ready, pass;
    bun_t b;
    m_accepted = 0;
    if (rst) begin
      m_wait = 0; m_ov = 0; m_err = 0; m_ts = 0; m_redir = 0; m_elapsed = 0;
      m_rw = 0; m_mw = 0; m_mpw = 0; m_m2r = 0; m_alu = 0; m_flags = 0;
    end else begin
      ready   = !m_wait && (!m_ov || out_ready) && !m_redir;
      m_ts    = 0;
      m_redir = 0;
      if (m_ov && out_ready) m_ov = 0;
      if (m_wait) begin
        m_elapsed++;
        if (trig_done) begin
          emit(m_pend, 1, 1);
          if (m_pend.fw) m_flags = alu_flags;
          m_redir = m_pend.br;
          m_wait  = 0;
        end else if (m_elapsed == TO) begin
          emit(m_pend, 0, 1);
          m_err  = 1;
          m_wait = 0;
        end
      end else if (in_valid && ready) begin
        m_accepted = 1;
        b    = cur_in();
        pass = cond_ok(b.cond, m_flags);
        if (b.trig && pass) begin
          m_wait = 1; m_elapsed = 0; m_pend = b; m_ts = 1;
        end else begin
          emit(b, pass, pass);
          if (pass && b.fw) m_flags = alu_flags;
          m_redir = pass && b.br;
        end
      end
    end
  end

  // Single compare process, sampled mid-cycle.
  always @(negedge clk) begin
    check("in_ready", in_ready, !rst && !m_wait && (!m_ov || out_ready) && !m_redir);
    check("out_valid", out_valid, m_ov);
    check("out_regWrite", out_regWrite, m_rw);
    check("out_memWrite", out_memWrite, m_mw);
    check("out_memPixWrite", out_memPixWrite, m_mpw);
    check("out_memToReg", out_memToReg, m_m2r);
    check("out_aluControl", out_aluControl, m_alu);
    check("flags", flags, m_flags);
    check("trig_start", trig_start, m_ts);
    check("pc_src_o", pc_src_o, m_redir);
    check("flush_o", flush_o, m_redir);
    check("trig_err", trig_err, m_err);
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input bun_t b, input bit v);
    in_valid = v; in_regWrite = b.rw; in_memWrite = b.mw; in_memPixWrite = b.mpw;
    in_branch = b.br; in_aluSrc = b.src; in_flagWrite = b.fw; in_trigControl = b.trig;
    in_pcSrc = b.pcs; in_memToReg = b.m2r; in_aluControl = b.alu; in_cond = b.cond;
  endtask

  function automatic bun_t mk(input logic [3:0] alu, input logic rw, input logic fw,
                              input logic br, input logic trig, input logic [3:0] cond);
    bun_t b;
    b.rw = rw; b.mw = 0; b.mpw = 0; b.br = br; b.src = 0; b.fw = fw; b.trig = trig;
    b.pcs = br; b.m2r = alu[1:0]; b.alu = alu; b.cond = cond;
    return b;
  endfunction

  function automatic bun_t rand_bun();
    bun_t b;
    logic [3:0] conds [5] = '{4'h0, 4'h1, 4'hA, 4'hB, 4'hE};
    int k;
    b.rw = 1'($urandom); b.mw = 1'($urandom); b.mpw = 1'($urandom);
    b.src = 1'($urandom); b.fw = 1'($urandom); b.pcs = 1'($urandom);
    b.trig = ($urandom_range(0, 3) == 0);
    b.br = b.trig ? 1'b0 : ($urandom_range(0, 2) == 0);
    b.m2r = 2'($urandom); b.alu = 4'($urandom);
    k = $urandom_range(0, 5);
    b.cond = (k == 5) ? 4'($urandom) : conds[k];
    return b;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed + random stimulus ----------------
  initial begin
    bun_t idle_b, cur;
    bit   have;
    logic [3:0] tags [3] = '{4'b0000, 4'b1010, 4'b0001};
    idle_b = mk(4'h0, 0, 0, 0, 0, 4'hE);
    rst = 1; out_ready = 1; trig_done = 0; alu_flags = 0;
    apply(idle_b, 0);

    // Reset: in_ready low during rst, high in the first cycle after.
    repeat (3) begin
      tick();
      @(negedge clk); check("rst_in_ready_low", in_ready, 0);
    end
    tick(); rst = 0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_flags", flags, 0);
    check("post_rst_trig_err", trig_err, 0);

    // Back-to-back: three ops (incl. MUL) on consecutive cycles.
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i < 3) apply(mk(tags[i], 1, 0, 0, 0, 4'hE), 1); else in_valid = 0;
      @(negedge clk);
      if (i < 3) check("b2b_in_ready", in_ready, 1);
      if (i >= 1) begin
        check("b2b_out_valid", out_valid, 1);
        check("b2b_order", out_aluControl, tags[i-1]);
      end
    end

    // Backpressure: hold output 3 cycles, then release accepts next bundle.
    tick(); out_ready = 0; apply(mk(4'h5, 1, 0, 0, 0, 4'hE), 1);
    @(negedge clk); check("bp_first_ready", in_ready, 1);
    repeat (3) begin
      tick(); apply(mk(4'h6, 1, 0, 0, 0, 4'hE), 1);
      @(negedge clk);
      check("bp_in_ready_low", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
      check("bp_out_stable", out_aluControl, 4'h5);
    end
    tick(); out_ready = 1;
    @(negedge clk); check("bp_release_ready", in_ready, 1);
    tick(); in_valid = 0;
    @(negedge clk);
    check("bp_next_valid", out_valid, 1);
    check("bp_next_alu", out_aluControl, 4'h6);

    // Conditional execution on Z.
    tick(); apply(mk(4'h0, 1, 1, 0, 0, 4'hE), 1); alu_flags = 4'b0100;
    tick(); apply(mk(4'h3, 1, 0, 1, 0, 4'h1), 1); alu_flags = 4'b0000;
    @(negedge clk); check("cond_flags_z", flags, 4'b0100);
    tick(); apply(mk(4'h3, 1, 0, 1, 0, 4'h0), 1);
    @(negedge clk);
    check("ne_fail_regwrite", out_regWrite, 0);
    check("ne_fail_pc_src", pc_src_o, 0);
    tick(); in_valid = 0;
    @(negedge clk);
    check("eq_pc_src", pc_src_o, 1);
    check("eq_flush", flush_o, 1);
    check("eq_flush_ready", in_ready, 0);
    check("eq_regwrite", out_regWrite, 1);
    tick();
    @(negedge clk);
    check("eq_pc_src_one", pc_src_o, 0);
    check("eq_flush_one", flush_o, 0);

    // Trig op completing 5 cycles after trig_start.
    tick(); apply(mk(4'hC, 1, 1, 0, 1, 4'hE), 1);
    tick(); in_valid = 0;
    @(negedge clk);
    check("trig_start_pulse", trig_start, 1);
    check("trig_busy_ready", in_ready, 0);
    for (int k = 2; k <= 6; k++) begin
      tick();
      if (k == 6) begin trig_done = 1; alu_flags = 4'b1001; end
      @(negedge clk);
      check("trig_wait_ready", in_ready, 0);
      check("trig_wait_valid", out_valid, 0);
    end
    tick(); trig_done = 0;
    @(negedge clk);
    check("trig_out_valid", out_valid, 1);
    check("trig_out_alu", out_aluControl, 4'hC);
    check("trig_out_rw", out_regWrite, 1);
    check("trig_flags", flags, 4'b1001);

    // trig_done on the timeout cycle counts as completion.
    tick(); apply(mk(4'hD, 1, 0, 0, 1, 4'hE), 1);
    for (int k = 1; k <= 16; k++) begin
      tick(); in_valid = 0; trig_done = (k == 16);
    end
    tick(); trig_done = 0;
    @(negedge clk);
    check("edge_done_valid", out_valid, 1);
    check("edge_done_rw", out_regWrite, 1);
    check("edge_done_no_err", trig_err, 0);

    // Timeout without trig_done.
    tick(); apply(mk(4'hC, 1, 0, 0, 1, 4'hE), 1);
    for (int k = 1; k <= 16; k++) begin
      tick(); in_valid = 0;
      @(negedge clk);
      if (k == 16) begin
        check("to_pre_err", trig_err, 0);
        check("to_pre_valid", out_valid, 0);
      end
    end
    tick();
    @(negedge clk);
    check("to_err", trig_err, 1);
    check("to_valid", out_valid, 1);
    check("to_rw", out_regWrite, 0);
    check("to_idle_ready", in_ready, 1);
    repeat (5) begin
      tick();
      @(negedge clk); check("to_err_sticky", trig_err, 1);
    end

    // Reset in the 3rd TRIG_WAIT cycle; later trig_done ignored.
    tick(); apply(mk(4'hC, 1, 1, 1, 1, 4'hE), 1);
    tick(); in_valid = 0;
    tick();
    tick(); rst = 1;
    @(negedge clk); check("mid_rst_ready", in_ready, 0);
    tick(); rst = 0;
    @(negedge clk);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_ts", trig_start, 0);
    check("mid_rst_flags", flags, 0);
    check("mid_rst_err", trig_err, 0);
    check("mid_rst_pc", pc_src_o, 0);
    check("mid_rst_flush", flush_o, 0);
    check("mid_rst_alu", out_aluControl, 0);
    tick(); trig_done = 1;
    tick(); trig_done = 0;
    @(negedge clk); check("late_done_ignored", out_valid, 0);
    tick();
    @(negedge clk); check("late_done_ignored2", out_valid, 0);

    // Randomized traffic; the compare process checks every cycle.
    have = 0;
    cur  = idle_b;
    for (int n = 0; n < 4000; n++) begin
      tick();
      if (m_accepted || rst) have = 0;
      rst = ($urandom_range(0, 299) == 0);
      if (!have && $urandom_range(0, 3) != 0) begin
        cur  = rand_bun();
        have = 1;
      end
      apply(cur, have && ($urandom_range(0, 7) != 0));
      out_ready = ($urandom_range(0, 3) != 0);
      trig_done = ($urandom_range(0, 9) == 0);
      alu_flags = 4'($urandom);
    end
    tick(); in_valid = 0; rst = 0; trig_done = 0;
    repeat (3) tick();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
